// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
//   Collects key presses from the 4x4 keypad scanner into a 4-digit BCD entry.
//   Digits shift in from the right. BACKSPACE drops the newest digit, CLEAR
//   empties the buffer, and ENTER commits the buffer. A partial entry that sees
//   no key press for TIMEOUT_CYCLES clocks is discarded.
//
// Ports
//   clk            system clock
//   reset_p        synchronous, active-high reset
//   key_value      scanned key code, valid while key_valid=1
//   key_valid      level from the scanner, high while a key is held
//   display_value  live entry buffer, 4 BCD nibbles, [15:12] most significant
//   entered_value  last committed entry, held until the next commit
//   entry_done     one-cycle pulse when entered_value updates
//   entry_err      one-cycle pulse on a rejected key
//   entry_timeout  one-cycle pulse when an idle entry is discarded
//   digit_count    number of digits in the buffer, 0..4
//   busy           high whenever the buffer holds at least one digit
//
// State | meaning
// EMPTY | no digits buffered, idle timer held at 0
// ENTRY | 1-3 digits buffered, idle timer running
// FULL  | 4 digits buffered, further digits rejected, idle timer running

module keypad_entry_ctrl #(
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int CNT_W          = 32
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic [3:0]  key_value,
    input  logic        key_valid,
    output logic [15:0] display_value,
    output logic [15:0] entered_value,
    output logic        entry_done,
    output logic        entry_err,
    output logic        entry_timeout,
    output logic [2:0]  digit_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    state_t             state_n;
    logic [15:0]        entry_buf;
    logic [15:0]        buf_n;
    logic [15:0]        entered_n;
    logic [2:0]         count_n;
    logic               done_n;
    logic               err_n;
    logic               timeout_n;
    logic               kv_d;
    logic [CNT_W-1:0]   idle_cnt;
    logic [CNT_W-1:0]   idle_n;
    logic               press;
    logic               idle_expired;

    // One action per press: only the first cycle of key_valid counts.
    assign press        = key_valid & ~kv_d;
    assign idle_expired = (idle_cnt == IDLE_LAST);

    assign display_value = entry_buf;
    assign busy          = (state != EMPTY);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state         <= EMPTY;
            entry_buf     <= '0;
            entered_value <= '0;
            digit_count   <= '0;
            entry_done    <= 1'b0;
            entry_err     <= 1'b0;
            entry_timeout <= 1'b0;
            kv_d          <= 1'b0;
            idle_cnt      <= '0;
        end else begin
            state         <= state_n;
            entry_buf     <= buf_n;
            entered_value <= entered_n;
            digit_count   <= count_n;
            entry_done    <= done_n;
            entry_err     <= err_n;
            entry_timeout <= timeout_n;
            kv_d          <= key_valid;
            idle_cnt      <= idle_n;
        end
    end

    always_comb begin
        buf_n     = entry_buf;
        count_n   = digit_count;
        entered_n = entered_value;
        done_n    = 1'b0;
        err_n     = 1'b0;
        timeout_n = 1'b0;
        idle_n    = '0;
        state_n   = EMPTY;

        case (state)
            EMPTY, ENTRY, FULL: begin
                // A press always wins over an expiring idle timer; the
                // counter stays 0 because any press restarts it.
                if (press) begin
                    if (key_value <= 4'h9) begin
                        if (state == FULL) begin
                            err_n = 1'b1;
                        end else begin
                            buf_n   = {entry_buf[11:0], key_value};
                            count_n = digit_count + 3'd1;
                        end
                    end else begin
                        case (key_value)
                            4'hA: begin
                                if (state != EMPTY) begin
                                    buf_n   = {4'h0, entry_buf[15:4]};
                                    count_n = digit_count - 3'd1;
                                end
                            end
                            4'hB: begin
                                buf_n   = '0;
                                count_n = '0;
                            end
                            4'hC: begin
                                if (state != EMPTY) begin
                                    entered_n = entry_buf;
                                    done_n    = 1'b1;
                                    buf_n     = '0;
                                    count_n   = '0;
                                end else begin
                                    err_n = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (state != EMPTY) begin
                    if (idle_expired) begin
                        buf_n     = '0;
                        count_n   = '0;
                        timeout_n = 1'b1;
                    end else begin
                        idle_n = idle_cnt + CNT_W'(1);
                    end
                end

                if (count_n == 3'd0) begin
                    state_n = EMPTY;
                end else if (count_n == 3'd4) begin
                    state_n = FULL;
                end else begin
                    state_n = ENTRY;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a clean, empty entry.
                buf_n   = '0;
                count_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
module tb_keypad_entry_ctrl;

    logic        clk;
    logic        reset_p;
    logic [3:0]  key_value;
    logic        key_valid;
    logic [15:0] display_value;
    logic [15:0] entered_value;
    logic        entry_done;
    logic        entry_err;
    logic        entry_timeout;
    logic [2:0]  digit_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Pulse outputs seen right after the press edge and one cycle later.
    logic s_done, s_err, s_to, s_done2, s_err2, s_to2;

    keypad_entry_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk           (clk),
        .reset_p       (reset_p),
        .key_value     (key_value),
        .key_valid     (key_valid),
        .display_value (display_value),
        .entered_value (entered_value),
        .entry_done    (entry_done),
        .entry_err     (entry_err),
        .entry_timeout (entry_timeout),
        .digit_count   (digit_count),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Press: key held 5 cycles then released 5 cycles.
    task automatic press_full(input logic [3:0] k);
        key_value = k;
        key_valid = 1'b1;
        tick();
        s_done = entry_done; s_err = entry_err; s_to = entry_timeout;
        tick();
        s_done2 = entry_done; s_err2 = entry_err; s_to2 = entry_timeout;
        repeat (3) tick();
        key_valid = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        reset_p   = 1'b1;
        key_value = 4'h0;
        key_valid = 1'b0;
        repeat (3) tick();
        chk("rst_display", 32'(display_value), 32'h0);
        chk("rst_entered", 32'(entered_value), 32'h0);
        chk("rst_count", 32'(digit_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", {29'd0, entry_done, entry_err, entry_timeout}, 32'd0);
        reset_p = 1'b0;
        tick();

        // Four digits then ENTER
        press_full(4'h1);
        chk("d1_display", 32'(display_value), 32'h0001);
        chk("d1_busy", 32'(busy), 32'd1);
        press_full(4'h2);
        chk("d2_display", 32'(display_value), 32'h0012);
        press_full(4'h3);
        chk("d3_display", 32'(display_value), 32'h0123);
        press_full(4'h4);
        chk("d4_display", 32'(display_value), 32'h1234);
        chk("d4_count", 32'(digit_count), 32'd4);
        press_full(4'hC);
        chk("enter_done_pulse", 32'(s_done), 32'd1);
        chk("enter_done_low", 32'(s_done2), 32'd0);
        chk("enter_entered", 32'(entered_value), 32'h1234);
        chk("enter_display", 32'(display_value), 32'h0000);
        chk("enter_count", 32'(digit_count), 32'd0);
        chk("enter_busy", 32'(busy), 32'd0);

        // Fifth digit rejected when FULL, then BACKSPACE
        press_full(4'h1);
        press_full(4'h2);
        press_full(4'h3);
        press_full(4'h4);
        press_full(4'h5);
        chk("full_err_pulse", 32'(s_err), 32'd1);
        chk("full_err_low", 32'(s_err2), 32'd0);
        chk("full_display", 32'(display_value), 32'h1234);
        chk("full_count", 32'(digit_count), 32'd4);
        press_full(4'hA);
        chk("bs_display", 32'(display_value), 32'h0123);
        chk("bs_count", 32'(digit_count), 32'd3);
        press_full(4'hB);
        chk("clr_display", 32'(display_value), 32'h0000);

        // Held key acts once; the hold does not restart the idle timer
        key_value = 4'h7;
        key_valid = 1'b1;
        repeat (10) tick();
        chk("hold_display", 32'(display_value), 32'h0007);
        chk("hold_count", 32'(digit_count), 32'd1);
        repeat (90) tick();
        chk("hold_end_display", 32'(display_value), 32'h0000);
        chk("hold_end_count", 32'(digit_count), 32'd0);
        key_valid = 1'b0;
        repeat (3) tick();

        // ENTER on an empty buffer
        press_full(4'hC);
        chk("empty_enter_err", 32'(s_err), 32'd1);
        chk("empty_enter_done", 32'(s_done), 32'd0);
        chk("empty_enter_entered", 32'(entered_value), 32'h1234);

        // CLEAR mid-entry, BACKSPACE when empty
        press_full(4'h4);
        press_full(4'h2);
        chk("42_display", 32'(display_value), 32'h0042);
        press_full(4'hB);
        chk("clr42_display", 32'(display_value), 32'h0000);
        chk("clr42_count", 32'(digit_count), 32'd0);
        chk("clr42_pulses", {29'd0, s_done, s_err, s_to}, 32'd0);
        press_full(4'hA);
        chk("bs_empty_pulses", {29'd0, s_done, s_err, s_to}, 32'd0);
        chk("bs_empty_display", 32'(display_value), 32'h0000);

        // Ignored key
        press_full(4'h3);
        press_full(4'hF);
        chk("ign_display", 32'(display_value), 32'h0003);
        chk("ign_count", 32'(digit_count), 32'd1);
        chk("ign_pulses", {29'd0, s_done, s_err, s_to}, 32'd0);
        press_full(4'hB);

        // Timeout exactly 16 cycles after the press edge
        key_value = 4'h9;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (15) tick();
        chk("to_before_pulse", 32'(entry_timeout), 32'd0);
        chk("to_before_display", 32'(display_value), 32'h0009);
        tick();
        chk("to_pulse", 32'(entry_timeout), 32'd1);
        chk("to_display", 32'(display_value), 32'h0000);
        chk("to_busy", 32'(busy), 32'd0);
        tick();
        chk("to_pulse_low", 32'(entry_timeout), 32'd0);

        // Press on the expiring edge wins
        key_value = 4'h9;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (15) tick();
        key_value = 4'h1;
        key_valid = 1'b1;
        tick();
        chk("race_timeout", 32'(entry_timeout), 32'd0);
        chk("race_display", 32'(display_value), 32'h0091);
        chk("race_count", 32'(digit_count), 32'd2);
        tick();
        chk("race_timeout_next", 32'(entry_timeout), 32'd0);
        key_valid = 1'b0;
        repeat (3) tick();
        press_full(4'hB);

        // Reset while a key is held
        press_full(4'h5);
        press_full(4'h6);
        chk("pre_rst_display", 32'(display_value), 32'h0056);
        key_value = 4'h7;
        key_valid = 1'b1;
        reset_p   = 1'b1;
        tick();
        chk("mid_rst_display", 32'(display_value), 32'h0000);
        chk("mid_rst_entered", 32'(entered_value), 32'h0000);
        chk("mid_rst_count", 32'(digit_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset_p = 1'b0;
        tick();
        chk("post_rst_display", 32'(display_value), 32'h0007);
        chk("post_rst_count", 32'(digit_count), 32'd1);
        repeat (3) tick();
        chk("post_rst_hold", 32'(display_value), 32'h0007);
        key_valid = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
